// File: rtl/sys_ctrl.sv
// Command sequencer: parses the UART byte stream into register write/read and ALU
// commands, and returns read data or 16-bit ALU results as byte frames to the transmitter.
module sys_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    output logic [ADDR_WIDTH-1:0]   RF_ADDR,
    output logic                    RF_WR_EN,
    output logic [DATA_WIDTH-1:0]   RF_WR_DATA,
    output logic                    RF_RD_EN,
    input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
    input  logic                    RF_RD_VLD,
    output logic [FUN_WIDTH-1:0]    ALU_FUN,
    output logic                    ALU_EN,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VLD,
    output logic                    CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD,
    input  logic                    TX_BUSY
);

    localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_NP = DATA_WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_OP_A,
        ST_OP_B,
        ST_ALU_FUN,
        ST_ALU_WAIT,
        ST_TX_REQ,
        ST_TX_ACK,
        ST_TX_DONE
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [2*DATA_WIDTH-1:0] tx_buf_reg, tx_buf_next;
    logic [1:0]              tx_cnt_reg, tx_cnt_next;

    logic [ADDR_WIDTH-1:0]   rf_addr_reg, rf_addr_next;
    logic                    rf_wr_en_reg, rf_wr_en_next;
    logic [DATA_WIDTH-1:0]   rf_wr_data_reg, rf_wr_data_next;
    logic                    rf_rd_en_reg, rf_rd_en_next;
    logic [FUN_WIDTH-1:0]    alu_fun_reg, alu_fun_next;
    logic                    alu_en_reg, alu_en_next;
    logic                    clk_gate_en_reg, clk_gate_en_next;
    logic [DATA_WIDTH-1:0]   tx_p_data_reg, tx_p_data_next;
    logic                    tx_d_vld_reg, tx_d_vld_next;

    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        tx_buf_next     = tx_buf_reg;
        tx_cnt_next     = tx_cnt_reg;
        rf_addr_next    = rf_addr_reg;
        rf_wr_data_next = rf_wr_data_reg;
        alu_fun_next    = alu_fun_reg;
        tx_p_data_next  = tx_p_data_reg;
        rf_wr_en_next   = 1'b0;
        rf_rd_en_next   = 1'b0;
        alu_en_next     = 1'b0;
        tx_d_vld_next   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (RX_D_VLD) begin
                    case (RX_P_DATA)
                        CMD_WR:     state_next = ST_WR_ADDR;
                        CMD_RD:     state_next = ST_RD_ADDR;
                        CMD_ALU_OP: state_next = ST_OP_A;
                        CMD_ALU_NP: state_next = ST_ALU_FUN;
                        default:    state_next = ST_IDLE;
                    endcase
                end
            end
            ST_WR_ADDR: begin
                if (RX_D_VLD) begin
                    addr_next  = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_next = ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                if (RX_D_VLD) begin
                    rf_addr_next    = addr_reg;
                    rf_wr_data_next = RX_P_DATA;
                    rf_wr_en_next   = 1'b1;
                    state_next      = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                if (RX_D_VLD) begin
                    rf_addr_next  = RX_P_DATA[ADDR_WIDTH-1:0];
                    rf_rd_en_next = 1'b1;
                    state_next    = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (RF_RD_VLD) begin
                    tx_buf_next = {{DATA_WIDTH{1'b0}}, RF_RD_DATA};
                    tx_cnt_next = 2'd1;
                    state_next  = ST_TX_REQ;
                end
            end
            // Operands land in the two lowest registers, where the ALU reads them.
            ST_OP_A: begin
                if (RX_D_VLD) begin
                    rf_addr_next    = '0;
                    rf_wr_data_next = RX_P_DATA;
                    rf_wr_en_next   = 1'b1;
                    state_next      = ST_OP_B;
                end
            end
            ST_OP_B: begin
                if (RX_D_VLD) begin
                    rf_addr_next    = ADDR_WIDTH'(1);
                    rf_wr_data_next = RX_P_DATA;
                    rf_wr_en_next   = 1'b1;
                    state_next      = ST_ALU_FUN;
                end
            end
            ST_ALU_FUN: begin
                if (RX_D_VLD) begin
                    alu_fun_next = RX_P_DATA[FUN_WIDTH-1:0];
                    alu_en_next  = 1'b1;
                    state_next   = ST_ALU_WAIT;
                end
            end
            ST_ALU_WAIT: begin
                if (ALU_OUT_VLD) begin
                    tx_buf_next = ALU_OUT;
                    tx_cnt_next = 2'd2;
                    state_next  = ST_TX_REQ;
                end
            end
            ST_TX_REQ: begin
                if (!TX_BUSY) begin
                    tx_p_data_next = tx_buf_reg[DATA_WIDTH-1:0];
                    tx_d_vld_next  = 1'b1;
                    state_next     = ST_TX_ACK;
                end
            end
            ST_TX_ACK: begin
                if (TX_BUSY) state_next = ST_TX_DONE;
            end
            // The low byte is always sent first; shifting exposes the high byte next.
            ST_TX_DONE: begin
                if (!TX_BUSY) begin
                    tx_cnt_next = tx_cnt_reg - 2'd1;
                    if (tx_cnt_reg > 2'd1) begin
                        tx_buf_next = tx_buf_reg >> DATA_WIDTH;
                        state_next  = ST_TX_REQ;
                    end else begin
                        state_next  = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        clk_gate_en_next = (state_next == ST_ALU_FUN) || (state_next == ST_ALU_WAIT);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg       <= ST_IDLE;
            addr_reg        <= '0;
            tx_buf_reg      <= '0;
            tx_cnt_reg      <= '0;
            rf_addr_reg     <= '0;
            rf_wr_en_reg    <= 1'b0;
            rf_wr_data_reg  <= '0;
            rf_rd_en_reg    <= 1'b0;
            alu_fun_reg     <= '0;
            alu_en_reg      <= 1'b0;
            clk_gate_en_reg <= 1'b0;
            tx_p_data_reg   <= '0;
            tx_d_vld_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            addr_reg        <= addr_next;
            tx_buf_reg      <= tx_buf_next;
            tx_cnt_reg      <= tx_cnt_next;
            rf_addr_reg     <= rf_addr_next;
            rf_wr_en_reg    <= rf_wr_en_next;
            rf_wr_data_reg  <= rf_wr_data_next;
            rf_rd_en_reg    <= rf_rd_en_next;
            alu_fun_reg     <= alu_fun_next;
            alu_en_reg      <= alu_en_next;
            clk_gate_en_reg <= clk_gate_en_next;
            tx_p_data_reg   <= tx_p_data_next;
            tx_d_vld_reg    <= tx_d_vld_next;
        end
    end

    assign RF_ADDR     = rf_addr_reg;
    assign RF_WR_EN    = rf_wr_en_reg;
    assign RF_WR_DATA  = rf_wr_data_reg;
    assign RF_RD_EN    = rf_rd_en_reg;
    assign ALU_FUN     = alu_fun_reg;
    assign ALU_EN      = alu_en_reg;
    assign CLK_GATE_EN = clk_gate_en_reg;
    assign TX_P_DATA   = tx_p_data_reg;
    assign TX_D_VLD    = tx_d_vld_reg;

endmodule

// File: tb/tb_sys_ctrl.sv
// Randomized bench for sys_ctrl: register file, ALU and transmitter models around the DUT,
// with a command-level reference model predicting every strobe and transmitted byte.
module tb_sys_ctrl;

    logic        CLK;
    logic        RST         = 1'b0;
    logic [7:0]  RX_P_DATA   = 8'h00;
    logic        RX_D_VLD    = 1'b0;
    logic [3:0]  RF_ADDR;
    logic        RF_WR_EN;
    logic [7:0]  RF_WR_DATA;
    logic        RF_RD_EN;
    logic [7:0]  RF_RD_DATA  = 8'h00;
    logic        RF_RD_VLD   = 1'b0;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN;
    logic [15:0] ALU_OUT     = 16'h0000;
    logic        ALU_OUT_VLD = 1'b0;
    logic        CLK_GATE_EN;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        TX_BUSY     = 1'b0;

    sys_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4)) dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RF_ADDR(RF_ADDR), .RF_WR_EN(RF_WR_EN), .RF_WR_DATA(RF_WR_DATA),
        .RF_RD_EN(RF_RD_EN), .RF_RD_DATA(RF_RD_DATA), .RF_RD_VLD(RF_RD_VLD),
        .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN), .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
        .CLK_GATE_EN(CLK_GATE_EN),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Environment-side ALU behaviour (used by the ALU model and the reference alike).
    function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [3:0] f);
        case (f)
            4'd0:    return 16'(a) + 16'(b);
            4'd1:    return 16'(a) - 16'(b);
            4'd2:    return 16'(a) * 16'(b);
            4'd3:    return {8'h00, a & b};
            default: return {a ^ {4'h0, f}, b};
        endcase
    endfunction

    // Observed events (filled by the environment) and expected events (reference model)
    logic [11:0] obs_wr[$], exp_wr[$];
    logic [3:0]  obs_rd[$], exp_rd[$];
    logic [3:0]  obs_alu[$], exp_alu[$];
    logic [7:0]  obs_tx[$], exp_tx[$];

    logic [7:0]  env_mem[16];
    logic [7:0]  ref_mem[16];

    bit          rd_pend = 0;
    int          rd_cnt = 0;
    logic [3:0]  rd_addr = 4'h0;
    bit          alu_pend = 0;
    int          alu_cnt = 0;
    logic [15:0] alu_val = 16'h0;
    bit          alu_force = 0;
    logic [15:0] alu_force_val = 16'h0;
    int          tx_phase = 0;
    int          tx_cnt = 0;
    bit          long_busy = 0;

    initial begin
        for (int i = 0; i < 16; i++) begin
            env_mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
    end

    // Register file, ALU and transmitter models; DUT outputs are sampled on the falling edge.
    always @(negedge CLK) begin
        RF_RD_VLD   = 1'b0;
        ALU_OUT_VLD = 1'b0;
        RF_RD_DATA  = 8'($urandom);
        ALU_OUT     = 16'($urandom);
        if (!RST) begin
            rd_pend  = 0;
            alu_pend = 0;
        end
        if (RF_WR_EN) begin
            obs_wr.push_back({RF_ADDR, RF_WR_DATA});
            env_mem[RF_ADDR] = RF_WR_DATA;
        end
        if (RF_RD_EN) begin
            obs_rd.push_back(RF_ADDR);
            rd_pend = 1;
            rd_addr = RF_ADDR;
            rd_cnt  = $urandom_range(0, 4);
        end else if (rd_pend) begin
            if (rd_cnt == 0) begin
                RF_RD_VLD  = 1'b1;
                RF_RD_DATA = env_mem[rd_addr];
                rd_pend    = 0;
            end else begin
                rd_cnt--;
            end
        end else if ($urandom_range(0, 15) == 0) begin
            RF_RD_VLD = 1'b1;
        end
        if (ALU_EN) begin
            obs_alu.push_back(ALU_FUN);
            check("cg_on_alu_en", 32'(CLK_GATE_EN), 32'd1);
            alu_pend = 1;
            alu_val  = alu_force ? alu_force_val : alu_model(env_mem[0], env_mem[1], ALU_FUN);
            alu_cnt  = $urandom_range(0, 4);
        end else if (alu_pend) begin
            check("cg_alu_wait", 32'(CLK_GATE_EN), 32'd1);
            if (alu_cnt == 0) begin
                ALU_OUT_VLD = 1'b1;
                ALU_OUT     = alu_val;
                alu_pend    = 0;
            end else begin
                alu_cnt--;
            end
        end else if ($urandom_range(0, 15) == 0) begin
            ALU_OUT_VLD = 1'b1;
        end
        if (TX_D_VLD) begin
            check("tx_req_while_busy", 32'(tx_phase), 32'd0);
            obs_tx.push_back(TX_P_DATA);
            tx_phase = 1;
            tx_cnt   = $urandom_range(0, 2);
        end else if (tx_phase == 1) begin
            if (tx_cnt == 0) begin
                TX_BUSY   = 1'b1;
                tx_phase  = 2;
                tx_cnt    = long_busy ? 50 : $urandom_range(1, 5);
                long_busy = 0;
            end else begin
                tx_cnt--;
            end
        end else if (tx_phase == 2) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
                TX_BUSY  = 1'b0;
                tx_phase = 0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
        RX_P_DATA = 8'($urandom);
        repeat ($urandom_range(0, 2)) @(negedge CLK);
    endtask

    // Waits for n transmitted bytes; the DUT is busy meanwhile, so stray bytes are injected.
    task automatic wait_tx(input int n);
        int t = 0;
        while (t < 500 && obs_tx.size() < n) begin
            @(negedge CLK);
            t++;
            RX_D_VLD = 1'b0;
            if (obs_tx.size() < n && $urandom_range(0, 5) == 0) begin
                RX_D_VLD  = 1'b1;
                RX_P_DATA = 8'($urandom);
            end
        end
        @(negedge CLK);
        RX_D_VLD = 1'b0;
        check("tx_wait_in_time", 32'(t < 500), 32'd1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (t < 500 && tx_phase != 0) begin
            @(negedge CLK);
            t++;
        end
        repeat (2) @(negedge CLK);
        check("idle_in_time", 32'(t < 500), 32'd1);
    endtask

    task automatic compare_all();
        check("wr_count", 32'(obs_wr.size()), 32'(exp_wr.size()));
        while (obs_wr.size() > 0 && exp_wr.size() > 0)
            check("wr_addr_data", 32'(obs_wr.pop_front()), 32'(exp_wr.pop_front()));
        check("rd_count", 32'(obs_rd.size()), 32'(exp_rd.size()));
        while (obs_rd.size() > 0 && exp_rd.size() > 0)
            check("rd_addr", 32'(obs_rd.pop_front()), 32'(exp_rd.pop_front()));
        check("alu_count", 32'(obs_alu.size()), 32'(exp_alu.size()));
        while (obs_alu.size() > 0 && exp_alu.size() > 0)
            check("alu_fun", 32'(obs_alu.pop_front()), 32'(exp_alu.pop_front()));
        check("tx_count", 32'(obs_tx.size()), 32'(exp_tx.size()));
        while (obs_tx.size() > 0 && exp_tx.size() > 0)
            check("tx_byte", 32'(obs_tx.pop_front()), 32'(exp_tx.pop_front()));
        obs_wr.delete(); exp_wr.delete();
        obs_rd.delete(); exp_rd.delete();
        obs_alu.delete(); exp_alu.delete();
        obs_tx.delete(); exp_tx.delete();
        check("cg_idle", 32'(CLK_GATE_EN), 32'd0);
    endtask

    function automatic logic [31:0] out_vec();
        return {3'b000, RF_ADDR, RF_WR_EN, RF_WR_DATA, RF_RD_EN, ALU_FUN, ALU_EN,
                CLK_GATE_EN, TX_P_DATA, TX_D_VLD};
    endfunction

    task automatic do_wr(input int id, input logic [7:0] a, input logic [7:0] d);
        $display("txn %0d: WR addr %02h data %02h", id, a, d);
        exp_wr.push_back({a[3:0], d});
        ref_mem[a[3:0]] = d;
        send_byte(8'hAA);
        send_byte(a);
        send_byte(d);
        wait_idle();
        compare_all();
    endtask

    task automatic do_rd(input int id, input logic [7:0] a, input bit extra_drop);
        $display("txn %0d: RD addr %02h", id, a);
        exp_rd.push_back(a[3:0]);
        exp_tx.push_back(ref_mem[a[3:0]]);
        send_byte(8'hBB);
        send_byte(a);
        if (extra_drop) send_byte(8'hAA);
        wait_tx(1);
        wait_idle();
        compare_all();
    endtask

    task automatic do_alu(input int id, input bit with_ops, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] f,
                          input bit force_res, input logic [15:0] fval, input bit bp);
        logic [15:0] r;
        $display("txn %0d: ALU ops %0d a %02h b %02h fun %02h", id, with_ops, a, b, f);
        if (with_ops) begin
            exp_wr.push_back({4'h0, a});
            exp_wr.push_back({4'h1, b});
            ref_mem[0] = a;
            ref_mem[1] = b;
            send_byte(8'hCC);
            send_byte(a);
            send_byte(b);
        end else begin
            send_byte(8'hDD);
        end
        r = force_res ? fval : alu_model(ref_mem[0], ref_mem[1], f[3:0]);
        exp_alu.push_back(f[3:0]);
        exp_tx.push_back(r[7:0]);
        exp_tx.push_back(r[15:8]);
        alu_force     = force_res;
        alu_force_val = fval;
        long_busy     = bp;
        send_byte(f);
        if (bp) begin
            wait_tx(1);
            repeat (30) @(negedge CLK);
            check("bp_hold_second_byte", 32'(obs_tx.size()), 32'd1);
        end
        wait_tx(2);
        wait_idle();
        alu_force = 0;
        compare_all();
    endtask

    task automatic do_junk(input int id, input logic [7:0] b);
        $display("txn %0d: JUNK %02h", id, b);
        send_byte(b);
        repeat (3) @(negedge CLK);
        compare_all();
    endtask

    initial begin
        logic [7:0] jb;
        int kind;
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_outputs", out_vec(), 32'd0);
        RST = 1'b1;
        @(negedge CLK);

        do_wr(0, 8'h06, 8'hA5);
        do_rd(1, 8'h06, 1'b0);
        do_alu(2, 1'b1, 8'h05, 8'h04, 8'h00, 1'b1, 16'h0009, 1'b0);
        do_alu(3, 1'b0, 8'h00, 8'h00, 8'h01, 1'b1, 16'h0003, 1'b1);
        do_junk(4, 8'h55);
        do_rd(5, 8'h06, 1'b1);

        // Reset in the middle of a write command discards it.
        $display("txn 6: WR aborted by reset");
        send_byte(8'hAA);
        send_byte(8'h06);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("midcmd_reset_outputs", out_vec(), 32'd0);
        RST = 1'b1;
        send_byte(8'hA5);
        repeat (3) @(negedge CLK);
        compare_all();

        for (int i = 7; i < 87; i++) begin
            kind = $urandom_range(0, 4);
            case (kind)
                0: do_wr(i, 8'($urandom), 8'($urandom));
                1: do_rd(i, 8'($urandom), 1'($urandom));
                2: do_alu(i, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 16'h0, 1'b0);
                3: do_alu(i, 1'b0, 8'h00, 8'h00, 8'($urandom), 1'b0, 16'h0, 1'($urandom_range(0, 3) == 0));
                default: begin
                    jb = 8'($urandom);
                    while (jb == 8'hAA || jb == 8'hBB || jb == 8'hCC || jb == 8'hDD)
                        jb = 8'($urandom);
                    do_junk(i, jb);
                end
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        repeat (60000) @(posedge CLK);
        $display("FAIL watchdog: got no completion expected finish within 60000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
